// File: rtl/tester_flags_pkg.sv
// ---------------------------------------------------------------------------
// tester_flags_pkg
// Shared definitions for the branch-decision unit:
//   - condition-code constants (cond field)
//   - jump-operation constants (OP_TF field)
//   - flags_t: packed ALU status flags {o, s, c, z}
// ---------------------------------------------------------------------------
package tester_flags_pkg;

  // Condition codes; 011 and 110 are reserved and evaluate to false.
  localparam logic [2:0] COND_TRUE    = 3'b000;
  localparam logic [2:0] COND_NEG     = 3'b001;
  localparam logic [2:0] COND_ZERO    = 3'b010;
  localparam logic [2:0] COND_CARRY   = 3'b100;
  localparam logic [2:0] COND_NEGZERO = 3'b101;
  localparam logic [2:0] COND_OVF     = 3'b111;

  // Jump operations; 101 and 110 are reserved and behave like OP_NONE.
  localparam logic [2:0] OP_JF   = 3'b000;
  localparam logic [2:0] OP_JT   = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_JR   = 3'b100;
  localparam logic [2:0] OP_NONE = 3'b111;

  typedef struct packed {
    logic o;  // overflow
    logic s;  // sign
    logic c;  // carry
    logic z;  // zero
  } flags_t;

endpackage

// File: rtl/tester_flags_unit_if.sv
// ---------------------------------------------------------------------------
// tester_flags_unit_if
// Bundles the flag/condition/op inputs and the jump decision output.
//   O, S, C, Z : ALU status flags
//   cond       : 3-bit condition code
//   OP_TF      : 3-bit jump-operation code
//   out        : 1 = do not jump (PC+1), 0 = jump
// Modports:
//   master : drives flags/cond/OP_TF, observes out (control path / bench)
//   slave  : the decision unit
// ---------------------------------------------------------------------------
interface tester_flags_unit_if;
  logic       O;
  logic       S;
  logic       C;
  logic       Z;
  logic [2:0] cond;
  logic [2:0] OP_TF;
  logic       out;

  modport master (output O, S, C, Z, cond, OP_TF, input out);
  modport slave  (input  O, S, C, Z, cond, OP_TF, output out);
endinterface

// File: rtl/tester_flags_unit_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Maps the ALU flags and a condition code to the condition result c.
// Ports:
//   flags : packed {o, s, c, z}
//   cond  : condition code (see tester_flags_pkg)
//   c     : 1 when the selected condition holds; 0 for reserved codes
// ---------------------------------------------------------------------------
module cond_eval
  import tester_flags_pkg::*;
(
  input  flags_t     flags,
  input  logic [2:0] cond,
  output logic       c
);

  always_comb begin
    // NOTE: default assignment first so no path leaves c unassigned (no latch).
    c = 1'b0;
    case (cond)
      COND_TRUE:    c = 1'b1;
      COND_NEG:     c = flags.s;
      COND_ZERO:    c = flags.z;
      COND_CARRY:   c = flags.c;
      COND_NEGZERO: c = flags.s | flags.z;
      COND_OVF:     c = flags.o;
      default:      c = 1'b0;  // reserved codes never hold
    endcase
  end

endmodule

// File: rtl/tester_flags_unit.sv
// ---------------------------------------------------------------------------
// tester_flags_unit
// Branch-decision unit: evaluates the ALU flags against a condition code and
// a jump-operation code and tells PC-select whether to take the branch.
// Ports:
//   clk   : clock, used only with the registered output
//   rst_n : asynchronous active-low reset, used only with the registered output
//   bus   : tester_flags_unit_if.slave (O, S, C, Z, cond, OP_TF in; out out)
//           out = 1 means no jump, out = 0 means jump.
// Build option:
//   TESTER_FLAGS_REG_OUT_EN defined   -> out comes from a flop, 1-cycle
//                                        latency, async reset to 1 (no jump).
//   TESTER_FLAGS_REG_OUT_EN undefined -> out is purely combinational and
//                                        clk/rst_n are not used.
// ---------------------------------------------------------------------------
module tester_flags_unit
  import tester_flags_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  tester_flags_unit_if.slave  bus
);

  flags_t flags;
  logic   c;
  logic   decision;

  assign flags = '{o: bus.O, s: bus.S, c: bus.C, z: bus.Z};

  cond_eval u_cond_eval (
    .flags (flags),
    .cond  (bus.cond),
    .c     (c)
  );

  // Active-low decision: jf jumps when c is false, jt when c is true.
  always_comb begin
    decision = 1'b1;
    case (bus.OP_TF)
      OP_JF:              decision = c;
      OP_JT:              decision = ~c;
      OP_J, OP_JAL, OP_JR: decision = 1'b0;
      default:            decision = 1'b1;  // OP_NONE and reserved ops
    endcase
  end

`ifdef TESTER_FLAGS_REG_OUT_EN
  logic out_q;

  // Reset value 1 keeps the PC sequential while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment for flop state avoids simulation races.
    if (!rst_n) out_q <= 1'b1;
    else        out_q <= decision;
  end

  assign bus.out = out_q;
`else
  assign bus.out = decision;

  // clk/rst_n stay on the port list so both builds share one footprint.
  logic unused;
  assign unused = &{1'b0, clk, rst_n};
`endif

endmodule

// File: tb/tb_tester_flags_unit.sv
// ---------------------------------------------------------------------------
// tb_tester_flags_unit
// Directed and swept stimulus for tester_flags_unit; expected values come
// from hand-computed constants and a small reference function.
// Works for both builds (TESTER_FLAGS_REG_OUT_EN defined or not).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tester_flags_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  tester_flags_unit_if bus ();

  tester_flags_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // Reference decision; f is {O,S,C,Z}.
  function automatic logic ref_out(input logic [3:0] f, input logic [2:0] cnd,
                                   input logic [2:0] op);
    logic o, s, c, z, cv;
    {o, s, c, z} = f;
    case (cnd)
      3'd0:    cv = 1'b1;
      3'd1:    cv = s;
      3'd2:    cv = z;
      3'd4:    cv = c;
      3'd5:    cv = s | z;
      3'd7:    cv = o;
      default: cv = 1'b0;
    endcase
    if (op == 3'd0)                   return cv;
    else if (op == 3'd1)              return !cv;
    else if (op >= 3'd2 && op <= 3'd4) return 1'b0;
    else                              return 1'b1;
  endfunction

  task automatic drive(input logic [3:0] f, input logic [2:0] cnd,
                       input logic [2:0] op);
    {bus.O, bus.S, bus.C, bus.Z} = f;
    bus.cond  = cnd;
    bus.OP_TF = op;
  endtask

  // Drive inputs and wait until out should reflect them.
  task automatic apply(input logic [3:0] f, input logic [2:0] cnd,
                       input logic [2:0] op);
`ifdef TESTER_FLAGS_REG_OUT_EN
    @(negedge clk);
    drive(f, cnd, op);
    @(posedge clk);
    #1;
`else
    drive(f, cnd, op);
    #1;
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    drive(4'b0000, 3'b000, 3'b010);  // unconditional jump during reset
    #12;
`ifdef TESTER_FLAGS_REG_OUT_EN
    check("reset_holds_no_jump", bus.out, 1'b1);
`else
    check("reset_ignored_comb", bus.out, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Full sweep of every op, cond and flag combination.
    for (int op = 0; op < 8; op++)
      for (int cnd = 0; cnd < 8; cnd++)
        for (int f = 0; f < 16; f++) begin
          apply(4'(f), 3'(cnd), 3'(op));
          check($sformatf("sweep op=%0d cond=%0d OSCZ=%04b", op, cnd, f[3:0]),
                bus.out, ref_out(4'(f), 3'(cnd), 3'(op)));
        end

    // jt negzero: S=0,Z=1 jumps; S=0,Z=0 does not.
    apply(4'b0001, 3'b101, 3'b001); check("jt_negzero_z1", bus.out, 1'b0);
    apply(4'b0000, 3'b101, 3'b001); check("jt_negzero_z0", bus.out, 1'b1);

    // jf carry: C=1 no jump, C=0 jump; O/S/Z are irrelevant.
    apply(4'b0010, 3'b100, 3'b000); check("jf_carry_c1", bus.out, 1'b1);
    apply(4'b0000, 3'b100, 3'b000); check("jf_carry_c0", bus.out, 1'b0);
    apply(4'b1101, 3'b100, 3'b000); check("jf_carry_c0_osz", bus.out, 1'b0);
    apply(4'b1111, 3'b100, 3'b000); check("jf_carry_c1_osz", bus.out, 1'b1);

    // Never jump and unconditional ops.
    apply(4'b1111, 3'b000, 3'b111); check("never_all_ones", bus.out, 1'b1);
    apply(4'b0000, 3'b011, 3'b010); check("j_uncond",   bus.out, 1'b0);
    apply(4'b0000, 3'b110, 3'b011); check("jal_uncond", bus.out, 1'b0);
    apply(4'b0000, 3'b000, 3'b100); check("jr_uncond",  bus.out, 1'b0);

    // Reserved codes.
    apply(4'b1111, 3'b011, 3'b001); check("rsv_cond_jt", bus.out, 1'b1);
    apply(4'b0000, 3'b000, 3'b101); check("rsv_op101_a", bus.out, 1'b1);
    apply(4'b1111, 3'b111, 3'b101); check("rsv_op101_b", bus.out, 1'b1);
    apply(4'b0101, 3'b001, 3'b110); check("rsv_op110",   bus.out, 1'b1);

`ifdef TESTER_FLAGS_REG_OUT_EN
    // Reset mid-cycle forces no-jump without a clock edge.
    apply(4'b0000, 3'b000, 3'b010);
    check("pre_reset_jump", bus.out, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", bus.out, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 3'b000, 3'b111);
    @(posedge clk); #1;
    check("post_release_none", bus.out, 1'b1);
    // New decision appears only after the next rising edge.
    @(negedge clk);
    drive(4'b0000, 3'b000, 3'b010);
    #1;
    check("latency_before_edge", bus.out, 1'b1);
    @(posedge clk); #1;
    check("latency_after_edge", bus.out, 1'b0);
`else
    // clk/rst_n have no influence on the combinational decision.
    drive(4'b0000, 3'b000, 3'b010);
    rst_n = 1'b0;
    #1;
    check("comb_reset_no_effect", bus.out, 1'b0);
    rst_n = 1'b1;
    drive(4'b0000, 3'b000, 3'b111);
    #1;
    check("comb_zero_latency", bus.out, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
